// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: default geometry, chunk sizing and configuration check for pipelined_adder
package pipelined_adder_pkg;
   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_STAGES = 4;
   function automatic int chunk_width(input int width, input int stages);
      return stages > 0 ? width / stages : 1;
   endfunction
   function automatic bit config_ok(input int width, input int stages);
      return width >= 1 && stages >= 1 && stages <= width && width % stages == 0;
   endfunction
endpackage

// File: rtl/adder_slice.sv
// adder_slice: one CHUNK-bit carry slice with its pipeline register and valid/ready stage
// Optional signed-overflow flag in the last slice when PIPELINED_ADDER_OVF_EN is defined.
module adder_slice #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4,
   parameter int IDX = 0,
   parameter bit LAST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_sum,
   input  logic             i_carry,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_a,
   output logic [WIDTH-1:0] o_b,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry
`ifdef PIPELINED_ADDER_OVF_EN
   ,
   output logic             o_ovf
`endif
);
   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] sum;
      logic             carry;
   } slice_t;

   slice_t           r_slice;
   logic [CHUNK-1:0] w_chunk;
   logic             w_carry;
   logic [WIDTH-1:0] w_sum;

   assign {w_carry, w_chunk} = {1'b0, i_a[IDX*CHUNK +: CHUNK]} + {1'b0, i_b[IDX*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, i_carry};
   // Bits at and above this chunk are still zero in the incoming partial sum, so OR splices the chunk in
   assign w_sum = i_sum | (WIDTH'(w_chunk) << (IDX * CHUNK));
   assign o_ready = !r_slice.valid || i_ready;
   assign o_valid = r_slice.valid;
   assign o_a = r_slice.a;
   assign o_b = r_slice.b;
   assign o_sum = r_slice.sum;
   assign o_carry = r_slice.carry;

   // Load on every free/draining cycle; data only changes when a valid word transfers in
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_slice <= '0;
      else if (o_ready) begin
         r_slice.valid <= i_valid;
         if (i_valid) begin
            r_slice.a <= i_a;
            r_slice.b <= i_b;
            r_slice.sum <= w_sum;
            r_slice.carry <= w_carry;
         end
      end
   end

`ifdef PIPELINED_ADDER_OVF_EN
   logic r_ovf;
   if (LAST) begin : g_ovf
      // Carry into the MSB (a^b^sum at MSB) differing from carry out of it flags signed overflow
      always_ff @(posedge clk or posedge rst) begin
         if (rst) r_ovf <= 1'b0;
         else if (o_ready && i_valid) r_ovf <= i_a[WIDTH-1] ^ i_b[WIDTH-1] ^ w_chunk[CHUNK-1] ^ w_carry;
      end
   end else begin : g_no_ovf
      assign r_ovf = 1'b0;
   end
   assign o_ovf = r_ovf;
`endif
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit a+b+c_in split across STAGES registered slices with valid/ready on both sides
// Define PIPELINED_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int STAGES = DEFAULT_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
`ifdef PIPELINED_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CHUNK = chunk_width(WIDTH, STAGES);

   if (!config_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $error("pipelined_adder: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
   end

   logic             w_valid [STAGES+1];
   logic             w_ready [STAGES+1];
   logic [WIDTH-1:0] w_a     [STAGES+1];
   logic [WIDTH-1:0] w_b     [STAGES+1];
   logic [WIDTH-1:0] w_sum   [STAGES+1];
   logic             w_carry [STAGES+1];
`ifdef PIPELINED_ADDER_OVF_EN
   logic             w_ovf   [STAGES];
`endif

   assign w_ready[STAGES] = out_ready;
   assign in_ready = w_ready[0];

   genvar k;
   for (k = 0; k < STAGES; k++) begin : g_slice
      if (k == 0) begin : g_first
         assign w_valid[0] = in_valid;
         assign w_a[0] = a;
         assign w_b[0] = b;
         assign w_sum[0] = '0;
         assign w_carry[0] = c_in;
      end
      if (k == STAGES - 1) begin : g_last
         assign out_valid = w_valid[STAGES];
         assign sum = w_sum[STAGES];
         assign c_out = w_carry[STAGES];
`ifdef PIPELINED_ADDER_OVF_EN
         assign ovf = w_ovf[k];
`endif
      end
      adder_slice #(
         .WIDTH(WIDTH),
         .CHUNK(CHUNK),
         .IDX(k),
         .LAST(k == STAGES - 1)
      ) u_slice (
         .clk(clk),
         .rst(rst),
         .i_valid(w_valid[k]),
         .o_ready(w_ready[k]),
         .i_a(w_a[k]),
         .i_b(w_b[k]),
         .i_sum(w_sum[k]),
         .i_carry(w_carry[k]),
         .o_valid(w_valid[k+1]),
         .i_ready(w_ready[k+1]),
         .o_a(w_a[k+1]),
         .o_b(w_b[k+1]),
         .o_sum(w_sum[k+1]),
         .o_carry(w_carry[k+1])
`ifdef PIPELINED_ADDER_OVF_EN
         ,
         .o_ovf(w_ovf[k])
`endif
      );
   end
endmodule
